// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC bus arbiter.
//   state_t   : arbiter FSM states (idle, bus granted, turnaround gap)
//   CTRL_IDLE : idle level of the active-low control lines
//   DATA_IDLE : idle level of every data bit
//   clog2     : ceiling log2 used to size counters and indices
package rtc_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic CTRL_IDLE = 1'b1;
  localparam logic DATA_IDLE = 1'b0;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_rr_pick.sv
// rr_pick: combinational winner selection for the RTC bus arbiter.
//   req    : per-channel request vector
//   last   : index of the previous winner
//   mode   : 1 = round-robin (search from last+1), 0 = lowest index wins
//   winner : one-hot winner, all zero when nothing is requested
module rr_pick #(
  parameter int NCH = 3,
  parameter int LW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [LW-1:0]  last,
  input  logic           mode,
  output logic [NCH-1:0] winner
);

  logic [LW-1:0] idx;
  logic          hit;
  logic          found;

  // Walk the channels in search order; the first requesting one wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    hit    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx    = mode ? LW'((int'(last) + 1 + i) % NCH) : LW'(i);
      hit    = ~found & req[idx];
      winner = winner | ({{(NCH-1){1'b0}}, hit} << idx);
      found  = found | hit;
    end
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: N-way registered multiplexer/arbiter for the RTC parallel bus.
// The granted channel owns the bus until done, req drop or hold watchdog;
// the bus is held at idle levels for TURN cycles between owners.
//   clk, reset_n               : clock, asynchronous active-low reset
//   req, done                  : per-channel request level / end-of-transaction pulse
//   ad_i, cs_i, rd_i, wr_i, d_i: per-channel bus values (data channel k at [k*DW +: DW])
//   grant                      : one-hot current owner
//   ad_o, cs_o, rd_o, wr_o, d_o: registered bus outputs
//   busy                       : high while granted or in turnaround
//   err                        : sticky hold-watchdog flag
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int DW      = 8,
  parameter int TURN    = 1,
  parameter int RR      = 1,
  parameter int MAXHOLD = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    done,
  input  logic [NCH-1:0]    ad_i,
  input  logic [NCH-1:0]    cs_i,
  input  logic [NCH-1:0]    rd_i,
  input  logic [NCH-1:0]    wr_i,
  input  logic [NCH*DW-1:0] d_i,
  output logic [NCH-1:0]    grant,
  output logic              ad_o,
  output logic              cs_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [DW-1:0]     d_o,
  output logic              busy,
  output logic              err
);

  localparam int   LW   = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam int   HW   = clog2(MAXHOLD + 1);
  localparam int   TW   = (clog2(TURN + 1) < 1) ? 1 : clog2(TURN + 1);
  localparam logic MODE = (RR != 0);

  state_t          state;
  logic [LW-1:0]   last;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [NCH-1:0]  win;
  logic [LW-1:0]   win_idx;
  logic            sel_done, sel_req, sel_ad, sel_cs, sel_rd, sel_wr;
  logic [DW-1:0]   sel_d;
  logic            hold_exp;
  logic            release_now;

  rr_pick #(.NCH(NCH), .LW(LW)) u_pick (
    .req    (req),
    .last   (last),
    .mode   (MODE),
    .winner (win)
  );

  // One-hot grant steers the owner's lines; winner is encoded for 'last'.
  always_comb begin
    sel_done = 1'b0;
    sel_req  = 1'b0;
    sel_ad   = 1'b0;
    sel_cs   = 1'b0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_d    = '0;
    win_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_done = sel_done | (done[k] & grant[k]);
      sel_req  = sel_req  | (req[k]  & grant[k]);
      sel_ad   = sel_ad   | (ad_i[k] & grant[k]);
      sel_cs   = sel_cs   | (cs_i[k] & grant[k]);
      sel_rd   = sel_rd   | (rd_i[k] & grant[k]);
      sel_wr   = sel_wr   | (wr_i[k] & grant[k]);
      sel_d    = sel_d    | (d_i[k*DW +: DW] & {DW{grant[k]}});
      win_idx  = win_idx  | (win[k] ? LW'(k) : LW'(0));
    end
  end

  assign hold_exp    = (hold_cnt == HW'(MAXHOLD - 1));
  assign release_now = sel_done | ~sel_req | hold_exp;

  // Arbiter FSM, counters and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      last     <= LW'(NCH - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      ad_o     <= CTRL_IDLE;
      cs_o     <= CTRL_IDLE;
      rd_o     <= CTRL_IDLE;
      wr_o     <= CTRL_IDLE;
      d_o      <= {DW{DATA_IDLE}};
    end else begin
      // Idle bus unless the owner keeps the bus this cycle.
      ad_o <= CTRL_IDLE;
      cs_o <= CTRL_IDLE;
      rd_o <= CTRL_IDLE;
      wr_o <= CTRL_IDLE;
      d_o  <= {DW{DATA_IDLE}};
      case (state)
        S_IDLE: begin
          if (|req) begin
            grant    <= win;
            last     <= win_idx;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_GRANT;
          end else begin
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            grant <= '0;
            // Only a pure timeout is an error; done or req drop wins a tie.
            if (hold_exp & sel_req & ~sel_done) begin
              err <= 1'b1;
            end else begin
              err <= err;
            end
            if (TURN == 0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              turn_cnt <= TW'(TURN);
              busy     <= 1'b1;
              state    <= S_TURN;
            end
          end else begin
            ad_o <= sel_ad;
            cs_o <= sel_cs;
            rd_o <= sel_rd;
            wr_o <= sel_wr;
            d_o  <= sel_d;
            busy <= 1'b1;
            if (hold_cnt != HW'(MAXHOLD)) begin
              hold_cnt <= hold_cnt + HW'(1);
            end else begin
              hold_cnt <= hold_cnt;
            end
          end
        end
        S_TURN: begin
          if (turn_cnt <= TW'(1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            turn_cnt <= turn_cnt - TW'(1);
            busy     <= 1'b1;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: two instances share stimulus, one round-robin
// with TURN=1 and one fixed-priority with TURN=0, both with MAXHOLD=4.
// A cycle model (owner / gap / held counts) predicts every output.
module tb_rtc_bus_arbiter;

  localparam int MAXH = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req, done, ad_i, cs_i, rd_i, wr_i;
  logic [23:0] d_i;

  logic [2:0] grant_a, grant_b;
  logic       ad_a, cs_a, rd_a, wr_a, busy_a, err_a;
  logic       ad_b, cs_b, rd_b, wr_b, busy_b, err_b;
  logic [7:0] d_a, d_b;
  logic [16:0] obs [2];

  int checks;
  int failures;

  // model state per instance: 0 = round-robin TURN=1, 1 = fixed TURN=0
  int   p_turn [2] = '{1, 0};
  bit   p_rr   [2] = '{1'b1, 1'b0};
  int   m_owner[2];
  int   m_gap  [2];
  int   m_held [2];
  int   m_last [2];
  logic m_ad[2], m_cs[2], m_rd[2], m_wr[2], m_busy[2], m_err[2];
  logic [7:0] m_d[2];

  rtc_bus_arbiter #(.NCH(3), .DW(8), .TURN(1), .RR(1), .MAXHOLD(MAXH)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .ad_i(ad_i), .cs_i(cs_i), .rd_i(rd_i), .wr_i(wr_i), .d_i(d_i),
    .grant(grant_a), .ad_o(ad_a), .cs_o(cs_a), .rd_o(rd_a), .wr_o(wr_a),
    .d_o(d_a), .busy(busy_a), .err(err_a)
  );

  rtc_bus_arbiter #(.NCH(3), .DW(8), .TURN(0), .RR(0), .MAXHOLD(MAXH)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .ad_i(ad_i), .cs_i(cs_i), .rd_i(rd_i), .wr_i(wr_i), .d_i(d_i),
    .grant(grant_b), .ad_o(ad_b), .cs_o(cs_b), .rd_o(rd_b), .wr_o(wr_b),
    .d_o(d_b), .busy(busy_b), .err(err_b)
  );

  assign obs[0] = {grant_a, ad_a, cs_a, rd_a, wr_a, d_a, busy_a, err_a};
  assign obs[1] = {grant_b, ad_b, cs_b, rd_b, wr_b, d_b, busy_b, err_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] expv(input int j);
    logic [2:0] g;
    g = (m_owner[j] >= 0) ? 3'(1 << m_owner[j]) : 3'b000;
    return {g, m_ad[j], m_cs[j], m_rd[j], m_wr[j], m_d[j], m_busy[j], m_err[j]};
  endfunction

  task automatic model_idle_bus(input int j);
    m_ad[j] = 1'b1; m_cs[j] = 1'b1; m_rd[j] = 1'b1; m_wr[j] = 1'b1; m_d[j] = 8'h00;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_owner[j] = -1; m_gap[j] = 0; m_held[j] = 0; m_last[j] = 2;
      m_busy[j] = 1'b0; m_err[j] = 1'b0;
      model_idle_bus(j);
    end
  endtask

  // One clock edge of the arbitration rules, using the inputs present at the edge.
  task automatic model_step();
    for (int j = 0; j < 2; j++) begin
      int o;
      int w;
      o = m_owner[j];
      if (o >= 0) begin
        if (done[o] || !req[o] || m_held[j] == MAXH - 1) begin
          if (!done[o] && req[o]) m_err[j] = 1'b1;
          m_owner[j] = -1;
          m_gap[j]   = p_turn[j];
          m_busy[j]  = (p_turn[j] > 0);
          model_idle_bus(j);
        end else begin
          m_ad[j] = ad_i[o]; m_cs[j] = cs_i[o]; m_rd[j] = rd_i[o]; m_wr[j] = wr_i[o];
          m_d[j]  = d_i[o*8 +: 8];
          m_held[j]++;
          m_busy[j] = 1'b1;
        end
      end else if (m_gap[j] > 0) begin
        m_gap[j]--;
        m_busy[j] = (m_gap[j] > 0);
        model_idle_bus(j);
      end else begin
        model_idle_bus(j);
        w = -1;
        for (int i = 0; i < 3; i++) begin
          int c;
          c = p_rr[j] ? (m_last[j] + 1 + i) % 3 : i;
          if (w < 0 && req[c]) w = c;
        end
        if (w >= 0) begin
          m_owner[j] = w; m_last[j] = w; m_held[j] = 0; m_busy[j] = 1'b1;
        end else begin
          m_busy[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_bus();
    ad_i = 3'($urandom); cs_i = 3'($urandom); rd_i = 3'($urandom); wr_i = 3'($urandom);
    d_i  = 24'($urandom);
  endtask

  task automatic idle_wait();
    req = 3'b000; done = 3'b000;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 3'b000; done = 3'b000;
    ad_i = 3'b111; cs_i = 3'b111; rd_i = 3'b111; wr_i = 3'b111; d_i = 24'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (obs[j] !== {3'b000, 4'b1111, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", j, obs[j], {3'b000, 4'b1111, 8'h00, 1'b0, 1'b0});
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    idle_wait();
    rand_bus();
    req = 3'b010; cs_i[1] = 1'b0; d_i[15:8] = 8'hA5;
    tick();
    checks++;
    if (grant_a !== 3'b010 || grant_b !== 3'b010) begin
      failures++;
      $display("FAIL single_grant got=%b/%b exp=010", grant_a, grant_b);
    end
    tick();
    checks++;
    if (cs_a !== 1'b0 || d_a !== 8'hA5 || cs_b !== 1'b0 || d_b !== 8'hA5) begin
      failures++;
      $display("FAIL single_bus got=%b,%h/%b,%h exp=0,a5", cs_a, d_a, cs_b, d_b);
    end
    done = 3'b010;
    tick();
    done = 3'b000; req = 3'b000;
    checks++;
    if (grant_a !== 3'b000 || cs_a !== 1'b1 || d_a !== 8'h00 || grant_b !== 3'b000 || d_b !== 8'h00) begin
      failures++;
      $display("FAIL single_release got=%b,%b,%h exp=000,1,00", grant_a, cs_a, d_a);
    end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (obs[j] !== expv(j)) begin
        failures++;
        $display("FAIL model_single inst=%0d got=%h exp=%h", j, obs[j], expv(j));
      end
    end
  endtask

  task automatic test_priority_and_rr();
    logic [2:0] pga, pgb, prev_a;
    int zero_a, zero_b;
    bit seen_a, seen_b;
    idle_wait();
    pga = 3'b000; pgb = 3'b000; prev_a = 3'b000;
    zero_a = 0; zero_b = 0; seen_a = 1'b0; seen_b = 1'b0;
    req = 3'b111;
    for (int c = 0; c < 60; c++) begin
      done = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'b000;
      rand_bus();
      tick();
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== expv(j)) begin
          failures++;
          $display("FAIL model_arb inst=%0d cyc=%0d got=%h exp=%h", j, c, obs[j], expv(j));
        end
      end
      // fixed priority: channel 0 always wins, gap of TURN+1 = 1 sample
      if (grant_b == 3'b000) begin
        if (pgb != 3'b000) begin seen_b = 1'b1; zero_b = 0; end
        zero_b++;
      end else begin
        checks++;
        if (grant_b !== 3'b001) begin
          failures++;
          $display("FAIL fixed_owner got=%b exp=001", grant_b);
        end
        if (pgb == 3'b000 && seen_b) begin
          checks++;
          if (zero_b != 1) begin
            failures++;
            $display("FAIL fixed_gap got=%0d exp=1", zero_b);
          end
        end
      end
      // round-robin: owners rotate 001->010->100, gap of TURN+1 = 2 samples
      if (grant_a == 3'b000) begin
        if (pga != 3'b000) begin seen_a = 1'b1; zero_a = 0; end
        zero_a++;
      end else if (pga == 3'b000) begin
        if (seen_a) begin
          checks++;
          if (grant_a !== {prev_a[1:0], prev_a[2]} || zero_a != 2) begin
            failures++;
            $display("FAIL rr_handoff got=%b gap=%0d exp=%b gap=2", grant_a, zero_a, {prev_a[1:0], prev_a[2]});
          end
        end
        prev_a = grant_a;
      end
      pga = grant_a; pgb = grant_b;
    end
    done = 3'b000;
  endtask

  task automatic test_watchdog();
    int cnt_a, cnt_b;
    idle_wait();
    cnt_a = 0; cnt_b = 0;
    req = 3'b100;
    for (int c = 0; c < 5; c++) begin
      rand_bus();
      tick();
      if (grant_a == 3'b100) cnt_a++;
      if (grant_b == 3'b100) cnt_b++;
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== expv(j)) begin
          failures++;
          $display("FAIL model_wdog inst=%0d got=%h exp=%h", j, obs[j], expv(j));
        end
      end
    end
    req = 3'b000;
    checks++;
    if (cnt_a != MAXH || cnt_b != MAXH || err_a !== 1'b1 || err_b !== 1'b1) begin
      failures++;
      $display("FAIL wdog_release got=%0d/%0d err=%b/%b exp=4/4 err=1/1", cnt_a, cnt_b, err_a, err_b);
    end
    // a normal transaction afterwards must not clear err
    repeat (2) tick();
    req = 3'b001;
    repeat (3) tick();
    done = 3'b001;
    tick();
    done = 3'b000; req = 3'b000;
    repeat (2) tick();
    checks++;
    if (err_a !== 1'b1 || err_b !== 1'b1 || grant_a !== 3'b000 || grant_b !== 3'b000) begin
      failures++;
      $display("FAIL wdog_sticky got=err %b/%b grant %b/%b exp=err 1/1 grant 000/000", err_a, err_b, grant_a, grant_b);
    end
  endtask

  task automatic test_req_drop();
    idle_wait();
    req = 3'b001;
    repeat (3) tick();
    req = 3'b010;
    tick();
    checks++;
    if (grant_b !== 3'b000 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL drop_release got=%b busy=%b exp=000 busy=0", grant_b, busy_b);
    end
    tick();
    checks++;
    if (grant_b !== 3'b010 || grant_a !== 3'b000) begin
      failures++;
      $display("FAIL drop_regrant got=%b/%b exp=000/010", grant_a, grant_b);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== expv(j)) begin
          failures++;
          $display("FAIL model_drop inst=%0d got=%h exp=%h", j, obs[j], expv(j));
        end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!req[k]) req[k] = ($urandom_range(0, 3) == 0);
        else req[k] = ($urandom_range(0, 15) != 0);
        done[k] = ($urandom_range(0, 4) == 0);
      end
      rand_bus();
      tick();
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== expv(j)) begin
          failures++;
          $display("FAIL model_rand inst=%0d cyc=%0d got=%h exp=%h", j, c, obs[j], expv(j));
        end
      end
    end
    done = 3'b000;
  endtask

  task automatic test_reset_mid();
    idle_wait();
    req = 3'b001; cs_i = 3'b110; d_i = 24'h00003C;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (obs[j] !== {3'b000, 4'b1111, 8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_mid inst=%0d got=%h exp=%h", j, obs[j], {3'b000, 4'b1111, 8'h00, 1'b0, 1'b0});
      end
    end
    model_reset();
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs[j] !== expv(j)) begin
          failures++;
          $display("FAIL model_post_reset inst=%0d got=%h exp=%h", j, obs[j], expv(j));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_priority_and_rr();
    test_watchdog();
    test_req_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Parametrised, registered bus multiplexer and arbiter for the RTC parallel bus (AD, CS, RD, WR, 8-bit data). It supersedes the fixed two-way read/write select with N requesting controllers, such as the read, write and init sequencers. Arbitration is fixed-priority or round-robin, the owner holds the bus until it signals completion, and the bus is forced to idle levels for a turnaround gap between owners. A hold-time watchdog forces release if a controller hangs. It sits between the sequencer FSMs and the RTC pin drivers.

## Interface
- NCH, 3: number of requesting channels (≥2).
- DW, 8: data bus width.
- TURN, 1: idle cycles inserted between owners (0 allowed).
- RR, 1: 1 = round-robin, 0 = fixed priority (lowest index wins).
- MAXHOLD, 255: maximum cycles a channel may own the bus before forced release (≥2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NCH  per-channel bus request, level, held until done.
- done  in  NCH  per-channel single-cycle end-of-transaction pulse.
- ad_i, cs_i, rd_i, wr_i  in  NCH each  per-channel control lines, active-low.
- d_i  in  NCH*DW  per-channel data; channel k occupies bits [k*DW +: DW].
- grant  out  NCH  one-hot ownership; all zero when no owner.
- ad_o, cs_o, rd_o, wr_o  out  1  final registered control lines.
- d_o  out  DW  final registered data.
- busy  out  1  high in GRANT and TURN.
- err  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, GRANT, TURN.
- Idle bus levels are ad_o = cs_o = rd_o = wr_o = 1 and d_o = 0. These are driven in IDLE and TURN.
- **IDLE:** if any req bit is set, select a winner, load grant one-hot, clear hold_cnt and go to GRANT. If no req bit is set, stay in IDLE.
- **Fixed priority:** the lowest set index wins.
- **Round-robin:** the search starts at last + 1 modulo NCH, where last is the previous winner (reset value NCH-1, so channel 0 wins first).
- **GRANT:** each cycle the outputs register the granted channel's ad/cs/rd/wr/d inputs. Non-granted inputs are ignored, and so are their done pulses. hold_cnt increments and saturates.
- **Release conditions** (checked in GRANT): done[g], or !req[g], or hold_cnt == MAXHOLD-1. On release, grant is cleared and the outputs go to idle levels on the same edge.
- **After release:** go to TURN with turn_cnt = TURN. If TURN = 0, go directly to IDLE.
- **Watchdog:** a release caused only by hold_cnt sets err.
- **TURN:** turn_cnt decrements each cycle. At 1 go to IDLE. Requests arriving during TURN wait.
- grant is never non-zero outside GRANT and is never more than one-hot.
- hold_cnt width is clog2(MAXHOLD+1).
- turn_cnt width is clog2(TURN+1), minimum 1 bit.

## Timing
- **Reset (asynchronous, any state):**
  - state = IDLE, grant = 0, busy = 0, err = 0, last = NCH-1.
  - Bus outputs return to idle levels immediately, including mid-transaction.
- **Request to grant:** req rising in cycle n gives grant high after edge n+1. The first registered channel values appear on the bus after edge n+2.
- **Input to output in GRANT:** 1 cycle.
- **done to release:** done in cycle m gives grant = 0 and idle bus after edge m+1.
- **Gap between owners:** the next grant is issued TURN+1 edges after release, because IDLE costs one cycle. Minimum gap between owners is TURN+1 idle cycles.
- **Simultaneous events:** done together with the watchdog expiring counts as a normal release, and err stays clear. The owner dropping req together with another channel raising req behaves as release followed by the normal gap.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state enum (IDLE/GRANT/TURN);
  - the idle-level constants (CTRL_IDLE = 1'b1, DATA_IDLE = 0);
  - a clog2 function.
- One sub-module, rr_pick: a combinational, parametrised priority/round-robin picker. Inputs are req, last and mode; output is a one-hot winner. The arbiter FSM, counters and output register stay in rtc_bus_arbiter.

## Test plan
- **Reset:** reset_n low mid-GRANT → outputs 1/1/1/1, d_o = 0, grant = 0, err = 0 asynchronously.
- **Single channel:** req = 3'b010; ch1 drives cs_i = 0, d = 8'hA5 → grant = 3'b010 after 1 edge; cs_o = 0, d_o = 8'hA5 after 2 edges. done pulse → idle bus 1 edge later.
- **Fixed priority:** RR = 0, req = 3'b111 held, owners release via done → order 0, 0, 0… Each handoff has TURN+1 idle cycles.
- **Round-robin:** RR = 1, req = 3'b111 held → grant sequence 001, 010, 100, 001. No grant overlap, and the bus is idle between owners.
- **Watchdog:** MAXHOLD = 4, ch2 holds req and never pulses done → release after 4 GRANT cycles, err = 1 and stays 1 through further normal transactions.
- **TURN = 0 and req drop:** owner drops req without done → release. The next requester is granted exactly 1 idle cycle later.
